rf_agu_banked: RTL

//  Parametrised AGU register file: DEPTH x WIDTH, 3 read ports, 2 write ports.

---
 rtl/rf_agu_banked.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rf_agu_banked.sv
// rtl/rf_agu_banked.sv - banked AGU register file, 3 read / 2 write ports with shadow bank
//
// Purpose: DEPTH x WIDTH register file with a primary and a shadow bank. A single
// swap pulse exchanges the active bank for fast interrupt context switch. Reads are
// combinational from the active bank, with optional same-cycle write forwarding.
// Two write ports; on an address clash port 2 wins and a one-cycle flag is raised.
//
// Ports:
//   Clk        in   1      clock, all state updates on rising edge
//   Rst_n      in   1      asynchronous reset, active low
//   in1, in2   in   WIDTH  write data for write ports 1 and 2
//   waddr1/2   in   AW     write addresses
//   write1/2   in   1      write enables
//   raddr1/2/3 in   AW     read addresses
//   swap       in   1      toggle the active bank at this edge
//   out1/2/3   out  WIDTH  combinational read data
//   bank       out  1      active bank (0 = primary, 1 = shadow)
//   wcollide   out  1      high for the cycle after both ports wrote the same address
module rf_agu_banked #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    localparam int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [AW-1:0]    waddr1,
    input  logic [AW-1:0]    waddr2,
    input  logic             write1,
    input  logic             write2,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic [AW-1:0]    raddr3,
    input  logic             swap,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             bank,
    output logic             wcollide
);

    // DEPTH need not be a power of two, so addresses can exceed the last register.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [WIDTH-1:0] mem_d [2][DEPTH];
    logic             bank_q, bank_d;
    logic             wcollide_q, wcollide_d;

    logic             we1_ok, we2_ok;
    logic [AW-1:0]    raddr_a [3];
    logic [WIDTH-1:0] rdata_a [3];

    // Writes to addresses past the end are dropped entirely, so they can
    // neither modify storage nor take part in a collision.
    assign we1_ok = write1 && ({1'b0, waddr1} < DEPTH_C);
    assign we2_ok = write2 && ({1'b0, waddr2} < DEPTH_C);

    // Next-state: writes go to the bank active during this cycle; port 2 is
    // applied last so it overrides port 1 on a clash.
    always_comb begin
        mem_d      = mem_q;
        bank_d     = bank_q ^ swap;
        wcollide_d = we1_ok && we2_ok && (waddr1 == waddr2);
        if (we1_ok) begin
            mem_d[bank_q][waddr1] = in1;
        end
        if (we2_ok) begin
            mem_d[bank_q][waddr2] = in2;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            bank_q     <= 1'b0;
            wcollide_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            bank_q     <= bank_d;
            wcollide_q <= wcollide_d;
        end
    end

    assign raddr_a[0] = raddr1;
    assign raddr_a[1] = raddr2;
    assign raddr_a[2] = raddr3;

    // Read ports use the pre-edge bank, so a swap cycle still reads (and
    // forwards into) the old bank. Forwarding is suppressed while reset is
    // asserted because pending writes are being discarded.
    for (genvar p = 0; p < 3; p++) begin : g_rd
        always_comb begin
            rdata_a[p] = '0;
            if ({1'b0, raddr_a[p]} < DEPTH_C) begin
                rdata_a[p] = mem_q[bank_q][raddr_a[p]];
                if ((BYPASS != 0) && Rst_n) begin
                    if (we2_ok && (raddr_a[p] == waddr2)) begin
                        rdata_a[p] = in2;
                    end else if (we1_ok && (raddr_a[p] == waddr1)) begin
                        rdata_a[p] = in1;
                    end
                end
            end
        end
    end

    assign out1     = rdata_a[0];
    assign out2     = rdata_a[1];
    assign out3     = rdata_a[2];
    assign bank     = bank_q;
    assign wcollide = wcollide_q;

endmodule
